// File: rtl/rect_motion_ctl_if.sv
// rect_motion_ctl_if: VGA/mouse inputs and position outputs of the motion controller.
interface rect_motion_ctl_if;
  logic        vblnk;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] x;
  logic [11:0] y;
  logic [1:0]  state;

  modport master (
    output vblnk, mouse_left, mouse_xpos, mouse_ypos,
    input  x, y, state
  );

  modport slave (
    input  vblnk, mouse_left, mouse_xpos, mouse_ypos,
    output x, y, state
  );
endinterface

// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: rectangle follows the mouse, then drops under gravity on a
// left-button press, bounces off the floor with damping and comes to rest.
// Position updates once per frame on the vblnk rising edge.
// Optional macro RECT_MOTION_AUTOREL_EN: leave REST automatically after REST_FRAMES ticks.
module rect_motion_ctl #(
`ifdef RECT_MOTION_AUTOREL_EN
  parameter int unsigned REST_FRAMES = 120,
`endif
  parameter int unsigned SCREEN_W   = 800,
  parameter int unsigned SCREEN_H   = 600,
  parameter int unsigned RECT_W     = 48,
  parameter int unsigned RECT_H     = 64,
  parameter int unsigned G          = 1,
  parameter int unsigned VMAX       = 32,
  parameter int unsigned DAMP_SHIFT = 1,
  parameter int unsigned V_MIN      = 2
) (
  input logic              clk,
  input logic              rst,
  rect_motion_ctl_if.slave bus
);

  localparam int unsigned CW = 12;
  localparam int unsigned SW = CW + 1;

  localparam logic [CW-1:0] XMAX  = CW'(SCREEN_W - RECT_W);
  localparam logic [CW-1:0] FLOOR = CW'(SCREEN_H - RECT_H);
  localparam logic [CW-1:0] GV    = CW'(G);
  localparam logic [CW-1:0] VMAXV = CW'(VMAX);
  localparam logic [CW-1:0] VMINV = CW'(V_MIN);

  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    FALL   = 2'd1,
    RISE   = 2'd2,
    REST   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [CW-1:0] vel_q, vel_d;
  logic          vblnk_q;
  logic          mouse_left_q;

  logic          tick;
  logic          press;
  logic [CW-1:0] v_inc;
  logic [CW-1:0] v_fall;
  logic [CW-1:0] v_rise;
  logic [CW-1:0] bounce;
  logic [SW-1:0] y_sum;

`ifdef RECT_MOTION_AUTOREL_EN
  localparam int unsigned RCW = $clog2(REST_FRAMES + 1);
  localparam logic [RCW-1:0] REST_LAST = RCW'(REST_FRAMES - 1);
  logic [RCW-1:0] rest_cnt_q, rest_cnt_d;
`endif

  assign tick  = bus.vblnk & ~vblnk_q;
  assign press = bus.mouse_left & ~mouse_left_q;

  // Per-frame velocity and position arithmetic; y sum is one bit wider to catch floor overshoot.
  always_comb begin
    v_inc  = vel_q + GV;
    v_fall = (v_inc > VMAXV) ? VMAXV : v_inc;
    y_sum  = {1'b0, y_q} + {1'b0, v_fall};
    bounce = v_fall >> DAMP_SHIFT;
    v_rise = vel_q - GV;
  end

  // Next-state and next-position logic; a press outranks a same-cycle tick.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
`ifdef RECT_MOTION_AUTOREL_EN
    rest_cnt_d = rest_cnt_q;
`endif
    case (state_q)
      FOLLOW: begin
        if (press) begin
          state_d = FALL;
          vel_d   = '0;
        end else if (tick) begin
          x_d = (bus.mouse_xpos > XMAX)  ? XMAX  : bus.mouse_xpos;
          y_d = (bus.mouse_ypos > FLOOR) ? FLOOR : bus.mouse_ypos;
        end
      end
      FALL: begin
        if (tick) begin
          if (y_sum >= {1'b0, FLOOR}) begin
            y_d = FLOOR;
            if (bounce < VMINV) begin
              state_d = REST;
              vel_d   = '0;
`ifdef RECT_MOTION_AUTOREL_EN
              rest_cnt_d = '0;
`endif
            end else begin
              state_d = RISE;
              vel_d   = bounce;
            end
          end else begin
            y_d   = y_sum[CW-1:0];
            vel_d = v_fall;
          end
        end
      end
      RISE: begin
        if (tick) begin
          if (vel_q <= GV) begin
            vel_d   = '0;
            state_d = FALL;
          end else if (y_q < v_rise) begin
            y_d     = '0;
            vel_d   = '0;
            state_d = FALL;
          end else begin
            y_d   = y_q - v_rise;
            vel_d = v_rise;
          end
        end
      end
      REST: begin
        if (press) begin
          state_d = FOLLOW;
        end
`ifdef RECT_MOTION_AUTOREL_EN
        else if (tick) begin
          if (rest_cnt_q == REST_LAST) begin
            state_d = FOLLOW;
          end else begin
            rest_cnt_d = rest_cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = FOLLOW;
    endcase
  end

  // State, position, velocity and edge-detect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FOLLOW;
      x_q          <= '0;
      y_q          <= '0;
      vel_q        <= '0;
      vblnk_q      <= 1'b0;
      mouse_left_q <= 1'b0;
`ifdef RECT_MOTION_AUTOREL_EN
      rest_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vel_q        <= vel_d;
      vblnk_q      <= bus.vblnk;
      mouse_left_q <= bus.mouse_left;
`ifdef RECT_MOTION_AUTOREL_EN
      rest_cnt_q   <= rest_cnt_d;
`endif
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl: directed and randomized checks of rect_motion_ctl against a
// frame-level reference model. Honors RECT_MOTION_AUTOREL_EN like the design.
`timescale 1ns/1ps
module tb_rect_motion_ctl;

  localparam int XMAX  = 752;
  localparam int FLOOR = 536;
  localparam int VMAXI = 32;
`ifdef RECT_MOTION_AUTOREL_EN
  localparam bit AUTOREL = 1'b1;
`else
  localparam bit AUTOREL = 1'b0;
`endif

  logic clk;
  logic rst;
  rect_motion_ctl_if bus ();

  rect_motion_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state: position, mode (0..3), velocity, rest frame count.
  int m_x, m_y, m_st, m_vel, m_cnt;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_st = 0; m_vel = 0; m_cnt = 0;
  endtask

  // One clock of frame-level behaviour given tick t and press p.
  task automatic model_step(input bit t, input bit p);
    int v;
    int mx;
    int my;
    mx = int'(bus.mouse_xpos);
    my = int'(bus.mouse_ypos);
    case (m_st)
      0: begin
        if (p) begin
          m_st = 1; m_vel = 0;
        end else if (t) begin
          m_x = (mx > XMAX) ? XMAX : mx;
          m_y = (my > FLOOR) ? FLOOR : my;
        end
      end
      1: if (t) begin
        v = m_vel + 1;
        if (v > VMAXI) v = VMAXI;
        if (m_y + v >= FLOOR) begin
          m_y = FLOOR;
          if (v / 2 < 2) begin
            m_st = 3; m_vel = 0; m_cnt = 0;
          end else begin
            m_st = 2; m_vel = v / 2;
          end
        end else begin
          m_y = m_y + v; m_vel = v;
        end
      end
      2: if (t) begin
        if (m_vel <= 1) begin
          m_vel = 0; m_st = 1;
        end else begin
          m_vel = m_vel - 1;
          if (m_y < m_vel) begin
            m_y = 0; m_st = 1; m_vel = 0;
          end else begin
            m_y = m_y - m_vel;
          end
        end
      end
      default: begin
        if (p) m_st = 0;
        else if (t && AUTOREL) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == 120) m_st = 0;
        end
      end
    endcase
  endtask

  // One frame-tick and/or press pulse; outputs are valid on return.
  task automatic pulse(input bit t, input bit p);
    @(negedge clk);
    bus.vblnk = t;
    bus.mouse_left = p;
    @(negedge clk);
    bus.vblnk = 1'b0;
    bus.mouse_left = 1'b0;
    model_step(t, p);
  endtask

  task automatic set_mouse(input int mx, input int my);
    bus.mouse_xpos = 12'(mx);
    bus.mouse_ypos = 12'(my);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vblnk = 1'b0;
    bus.mouse_left = 1'b0;
    set_mouse(300, 300);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.vblnk = ~bus.vblnk;
      checks++;
      if ({bus.x, bus.y, bus.state} !== 26'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got x=%0d y=%0d st=%0d want 0/0/0", i, bus.x, bus.y, bus.state);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.vblnk = 1'b0;
    model_reset();
    pulse(1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd300, 12'd300, 2'd0}) begin
      failures++;
      $display("FAIL reset_first_tick: got x=%0d y=%0d st=%0d want 300/300/0", bus.x, bus.y, bus.state);
    end
  endtask

  task automatic test_follow_clamp();
    set_mouse(790, 590);
    pulse(1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd752, 12'd536, 2'd0}) begin
      failures++;
      $display("FAIL follow_clamp: got x=%0d y=%0d st=%0d want 752/536/0", bus.x, bus.y, bus.state);
    end
    set_mouse(100, 200);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0);
      checks++;
      if ({bus.x, bus.y} !== {12'd752, 12'd536}) begin
        failures++;
        $display("FAIL follow_no_tick[%0d]: got x=%0d y=%0d want 752/536", i, bus.x, bus.y);
      end
    end
    pulse(1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd100, 12'd200, 2'd0}) begin
      failures++;
      $display("FAIL follow_track: got x=%0d y=%0d st=%0d want 100/200/0", bus.x, bus.y, bus.state);
    end
  endtask

  task automatic test_bounce();
    int exp_y  [15] = '{501, 503, 506, 510, 515, 521, 528, 536, 533, 531, 530, 530, 531, 533, 536};
    int exp_st [15] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 3};
    set_mouse(100, 500);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd100, 12'd500, 2'd1}) begin
      failures++;
      $display("FAIL bounce_press: got x=%0d y=%0d st=%0d want 100/500/1", bus.x, bus.y, bus.state);
    end
    for (int i = 0; i < 15; i++) begin
      pulse(1'b1, 1'b0);
      checks++;
      if ({bus.x, bus.y, bus.state} !== {12'd100, 12'(exp_y[i]), 2'(exp_st[i])}) begin
        failures++;
        $display("FAIL bounce_tick[%0d]: got x=%0d y=%0d st=%0d want 100/%0d/%0d",
                 i, bus.x, bus.y, bus.state, exp_y[i], exp_st[i]);
      end
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL bounce_release: got st=%0d want 0", bus.state);
    end
  endtask

  task automatic test_vmax();
    int n;
    set_mouse(100, 0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 32; i++) pulse(1'b1, 1'b0);
    checks++;
    if ({bus.y, bus.state} !== {12'd528, 2'd1}) begin
      failures++;
      $display("FAIL vmax_tick32: got y=%0d st=%0d want 528/1", bus.y, bus.state);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if ({bus.y, bus.state} !== {12'd536, 2'd2}) begin
      failures++;
      $display("FAIL vmax_floor: got y=%0d st=%0d want 536/2", bus.y, bus.state);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if ({bus.y, bus.state} !== {12'd521, 2'd2}) begin
      failures++;
      $display("FAIL vmax_rebound: got y=%0d st=%0d want 521/2", bus.y, bus.state);
    end
    n = 0;
    while (m_st != 3 && n < 400) begin
      pulse(1'b1, 1'b0);
      n++;
      checks++;
      if ({bus.x, bus.y, bus.state} !== {12'(m_x), 12'(m_y), 2'(m_st)}) begin
        failures++;
        $display("FAIL vmax_settle[%0d]: got x=%0d y=%0d st=%0d want %0d/%0d/%0d",
                 n, bus.x, bus.y, bus.state, m_x, m_y, m_st);
      end
    end
    checks++;
    if (m_st != 3) begin
      failures++;
      $display("FAIL vmax_settle_timeout: got st=%0d want 3", m_st);
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    int n;
    set_mouse(200, 300);
    pulse(1'b1, 1'b0);
    set_mouse(400, 100);
    pulse(1'b1, 1'b1);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd200, 12'd300, 2'd1}) begin
      failures++;
      $display("FAIL simul_follow: got x=%0d y=%0d st=%0d want 200/300/1", bus.x, bus.y, bus.state);
    end
    n = 0;
    while (m_st != 2 && n < 200) begin
      pulse(1'b1, 1'b0);
      n++;
    end
    pulse(1'b0, 1'b1);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'(m_x), 12'(m_y), 2'd2}) begin
      failures++;
      $display("FAIL simul_rise_press: got x=%0d y=%0d st=%0d want %0d/%0d/2",
               bus.x, bus.y, bus.state, m_x, m_y);
    end
    pulse(1'b1, 1'b1);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'(m_x), 12'(m_y), 2'(m_st)}) begin
      failures++;
      $display("FAIL simul_rise_tick_press: got x=%0d y=%0d st=%0d want %0d/%0d/%0d",
               bus.x, bus.y, bus.state, m_x, m_y, m_st);
    end
    n = 0;
    while (m_st != 1 && n < 200) begin
      pulse(1'b1, 1'b0);
      n++;
    end
    pulse(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({bus.x, bus.y, bus.state} !== 26'd0) begin
      failures++;
      $display("FAIL simul_reset_midfall: got x=%0d y=%0d st=%0d want 0/0/0", bus.x, bus.y, bus.state);
    end
  endtask

  task automatic test_rest_hold();
    int n;
    set_mouse(50, 530);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    n = 0;
    while (m_st != 3 && n < 50) begin
      pulse(1'b1, 1'b0);
      n++;
    end
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd50, 12'd536, 2'd3}) begin
      failures++;
      $display("FAIL rest_entry: got x=%0d y=%0d st=%0d want 50/536/3", bus.x, bus.y, bus.state);
    end
`ifdef RECT_MOTION_AUTOREL_EN
    for (int i = 0; i < 119; i++) pulse(1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd50, 12'd536, 2'd3}) begin
      failures++;
      $display("FAIL rest_119: got x=%0d y=%0d st=%0d want 50/536/3", bus.x, bus.y, bus.state);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL rest_autorel: got st=%0d want 0", bus.state);
    end
`else
    for (int i = 0; i < 500; i++) pulse(1'b1, 1'b0);
    checks++;
    if ({bus.x, bus.y, bus.state} !== {12'd50, 12'd536, 2'd3}) begin
      failures++;
      $display("FAIL rest_500: got x=%0d y=%0d st=%0d want 50/536/3", bus.x, bus.y, bus.state);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL rest_press: got st=%0d want 0", bus.state);
    end
`endif
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3) begin
        set_mouse(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        pulse(1'b1, 1'b0);
      end else if (r < 11) begin
        pulse(1'b1, 1'b0);
      end else if (r < 14) begin
        pulse(1'b0, 1'b1);
      end else if (r < 17) begin
        pulse(1'b1, 1'b1);
      end else if (r < 19) begin
        set_mouse(int'($urandom_range(0, 900)), int'($urandom_range(0, 700)));
        pulse(1'b0, 1'b0);
      end else begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
      checks++;
      if ({bus.x, bus.y, bus.state} !== {12'(m_x), 12'(m_y), 2'(m_st)}) begin
        failures++;
        $display("FAIL random[%0d] op=%0d: got x=%0d y=%0d st=%0d want %0d/%0d/%0d",
                 i, r, bus.x, bus.y, bus.state, m_x, m_y, m_st);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_follow_clamp();
    test_bounce();
    test_vmax();
    test_simultaneous();
    test_rest_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
